// File: rtl/rv_imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Holds the host FSM encoding, default sizing and the burst-counter helper.
package rv_imem_arbiter_pkg;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_ACK  = 1'b1
    } host_state_e;

    localparam int AW_DEFAULT       = 14;
    localparam int HOST_MAX_DEFAULT = 4;
    localparam int CNT_W            = 4;

    // Saturating increment: the burst count must never wrap back under the limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rv_imem_arbiter.sv
// Arbitrates the single-port IMEM between the fetch stage and the host/debug port.
// Host transactions take priority up to a burst limit; fetch gets every other slot.
module rv_imem_arbiter
    import rv_imem_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int HOST_MAX = HOST_MAX_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [31:0]   f_addr_i,
    output logic [31:0]   f_data_o,
    output logic          f_valid_o,
    input  logic          h_req_i,
    input  logic          h_we_i,
    input  logic [31:0]   h_addr_i,
    input  logic [31:0]   h_wdata_i,
    input  logic          h_halt_i,
    output logic          h_ack_o,
    output logic [31:0]   h_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam logic [CNT_W-1:0] HOST_MAX_C = CNT_W'(HOST_MAX);

    host_state_e      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             f_valid_reg, f_valid_next;
    logic             rst_seen_reg;
    logic             host_grant, fetch_grant;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= H_IDLE;
            cnt_reg      <= '0;
            f_valid_reg  <= 1'b0;
            rst_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            f_valid_reg  <= f_valid_next;
            rst_seen_reg <= 1'b1;
        end
    end

    always_comb begin
        host_grant   = 1'b0;
        fetch_grant  = 1'b0;
        state_next   = H_IDLE;
        cnt_next     = cnt_reg;
        f_valid_next = 1'b0;

        // Halt lifts the burst limit so a program load can stream uninterrupted.
        host_grant  = h_req_i && (state_reg == H_IDLE) && (h_halt_i || (cnt_reg < HOST_MAX_C));
        fetch_grant = !host_grant && !h_halt_i;

        if (state_reg == H_IDLE && host_grant) begin
            state_next = H_ACK;
        end

        if (host_grant) begin
            cnt_next = sat_inc(cnt_reg);
        end else if (fetch_grant || (!h_req_i && state_reg == H_IDLE)) begin
            cnt_next = '0;
        end

        // The first cycle out of reset never reports a fetch.
        f_valid_next = fetch_grant && rst_seen_reg;
    end

    // An idle memory still looks at the fetch address; only the strobe matters.
    assign mem_addr_o  = host_grant ? h_addr_i[AW+1:2] : f_addr_i[AW+1:2];
    assign mem_we_o    = host_grant && h_we_i;
    assign mem_wdata_o = h_wdata_i;

    assign f_data_o  = mem_rdata_i;
    assign f_valid_o = f_valid_reg;
    assign h_ack_o   = (state_reg == H_ACK);
    assign h_rdata_o = mem_rdata_i;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{h_addr_i[31:AW+2], h_addr_i[1:0], f_addr_i[31:AW+2], f_addr_i[1:0]};

endmodule

// File: tb/tb_rv_imem_arbiter.sv
// Scoreboard bench for rv_imem_arbiter: host acks and fetch words are checked by a monitor,
// arbitration timing by directed checks in the stimulus.
module tb_rv_imem_arbiter;

    localparam int AW    = 14;
    localparam int HMAX  = 2;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   f_addr;
    logic [31:0]   f_data;
    logic          f_valid;
    logic          h_req, h_we, h_halt;
    logic [31:0]   h_addr, h_wdata;
    logic          h_ack;
    logic [31:0]   h_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    rv_imem_arbiter #(.AW(AW), .HOST_MAX(HMAX)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .f_addr_i    (f_addr),
        .f_data_o    (f_data),
        .f_valid_o   (f_valid),
        .h_req_i     (h_req),
        .h_we_i      (h_we),
        .h_addr_i    (h_addr),
        .h_wdata_i   (h_wdata),
        .h_halt_i    (h_halt),
        .h_ack_o     (h_ack),
        .h_rdata_o   (h_rdata),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous single-port IMEM macro.
    logic [31:0] mem [0:WORDS-1];
    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] <= pat(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    // Reference contents, updated by the stimulus when a write is issued.
    logic [31:0] ref_mem [0:WORDS-1];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } hexp_t;
    hexp_t hq[$];

    int n_cmp = 0;
    int n_err = 0;
    int fv_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Fetch stage model: holds the PC until a valid word comes back.
    logic [31:0] pc_base = 32'h0;
    int          jump_seq = 0;
    initial begin
        int jump_seen;
        jump_seen = 0;
        f_addr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (jump_seq != jump_seen) begin
                jump_seen = jump_seq;
                f_addr = pc_base;
            end else if (f_valid) begin
                f_addr = pc_base + ((f_addr - pc_base + 32'd4) & 32'h3C);
            end
        end
    end

    logic [31:0] prev_faddr = 32'h0;
    always @(posedge clk) prev_faddr <= f_addr;

    // Monitor: every fetch word and every host ack is checked here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (f_valid) begin
                fv_count++;
                check("f_data", f_data, ref_mem[prev_faddr[AW+1:2]]);
            end
            if (h_ack) begin
                if (hq.size() == 0) begin
                    check("h_ack_unexpected", 32'(h_ack), 32'd0);
                end else begin
                    hexp_t e;
                    e = hq.pop_front();
                    $display("host %s addr=0x%08h data=0x%08h", e.we ? "write" : "read ",
                             e.addr, e.we ? e.data : h_rdata);
                    if (!e.we) check("h_rdata", h_rdata, e.data);
                end
            end
        end
    end

    // Issues one host transaction; returns the ack latency and the first-cycle memory drive.
    task automatic host_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input logic keep, output int cycles, output logic first_we,
                            output logic [AW-1:0] first_addr, output logic ack_fvalid);
        logic done;
        hexp_t e;
        h_we    = we;
        h_addr  = addr;
        h_wdata = data;
        h_req   = 1'b1;
        e.we    = we;
        e.addr  = addr;
        e.data  = we ? data : ref_mem[addr[AW+1:2]];
        hq.push_back(e);
        if (we) ref_mem[addr[AW+1:2]] = data;
        cycles     = 0;
        done       = 1'b0;
        first_we   = 1'b0;
        first_addr = '0;
        ack_fvalid = 1'b0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                first_we   = mem_we;
                first_addr = mem_addr;
            end
            if (h_ack) begin
                done       = 1'b1;
                ack_fvalid = f_valid;
            end
        end
        check("host_ack_seen", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) h_req = 1'b0;
    endtask

    initial begin
        int            cyc, snap;
        logic          fwe, afv;
        logic [AW-1:0] fadr;

        rst_n   = 1'b0;
        h_req   = 1'b0;
        h_we    = 1'b0;
        h_addr  = 32'h0;
        h_wdata = 32'h0;
        h_halt  = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = pat(i);

        // 1: reset state and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_f_valid", 32'(f_valid), 32'd0);
        check("rst_h_ack", 32'(h_ack), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_cycle_no_valid", 32'(f_valid), 32'd0);
        @(negedge clk);
        check("valid_after_first_grant", 32'(f_valid), 32'd1);
        repeat (20) @(negedge clk);

        // 2: host write steals one fetch slot
        @(posedge clk); #1;
        host_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, cyc, fwe, fadr, afv);
        check("t2_mem_we", 32'(fwe), 32'd1);
        check("t2_mem_addr", 32'(fadr), 32'h40);
        check("t2_ack_latency", 32'(cyc), 32'd2);
        check("t2_fetch_stolen", 32'(afv), 32'd0);
        @(negedge clk);
        check("t2_fetch_resumes", 32'(f_valid), 32'd1);

        // 3: host read back
        @(posedge clk); #1;
        host_txn(1'b0, 32'h0000_0100, 32'h0, 1'b0, cyc, fwe, fadr, afv);
        check("t3_no_write", 32'(fwe), 32'd0);
        check("t3_ack_latency", 32'(cyc), 32'd2);

        // 4: back-to-back host requests interleave with fetch
        repeat (3) @(posedge clk); #1;
        snap = fv_count;
        host_txn(1'b1, 32'h0000_0180, 32'h1111_1111, 1'b1, cyc, fwe, fadr, afv);
        check("t4_lat0", 32'(cyc), 32'd2);
        host_txn(1'b1, 32'h0000_0184, 32'h2222_2222, 1'b1, cyc, fwe, fadr, afv);
        check("t4_lat1", 32'(cyc), 32'd2);
        host_txn(1'b0, 32'h0000_0180, 32'h0, 1'b0, cyc, fwe, fadr, afv);
        check("t4_lat2", 32'(cyc), 32'd2);
        check("t4_fetch_slots", 32'(fv_count - snap), 32'd3);

        // 5: halted program load, then limit forces one fetch slot on release
        @(posedge clk); #1;
        h_halt  = 1'b1;
        pc_base = 32'h0000_0100;
        jump_seq++;
        @(negedge clk);
        check("t5_inflight_valid", 32'(f_valid), 32'd1);
        @(posedge clk); #1;
        snap = fv_count;
        for (int i = 0; i < 16; i++) begin
            host_txn(1'b1, 32'h0000_0100 + 32'(4 * i), 32'hC0DE_0000 | 32'(i), 1'b1,
                     cyc, fwe, fadr, afv);
            check("t5_load_latency", 32'(cyc), 32'd2);
        end
        check("t5_no_fetch_while_halted", 32'(fv_count - snap), 32'd0);
        h_halt = 1'b0;
        host_txn(1'b1, 32'h0000_0140, 32'h0BAD_F00D, 1'b0, cyc, fwe, fadr, afv);
        check("t5_limit_blocks_host", 32'(fwe), 32'd0);
        check("t5_limit_latency", 32'(cyc), 32'd3);
        snap = fv_count;
        repeat (40) @(posedge clk);
        #1;
        check("t5_readback_count", 32'(fv_count - snap), 32'd40);

        // 6: async reset in H_ACK with a fetch in flight
        @(posedge clk); #1;
        begin
            hexp_t e;
            h_we   = 1'b0;
            h_addr = 32'h0000_0104;
            h_req  = 1'b1;
            e.we   = 1'b0;
            e.addr = 32'h0000_0104;
            e.data = ref_mem[14'h41];
            hq.push_back(e);
        end
        @(negedge clk);
        check("t6_read_no_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("t6_in_ack", 32'(h_ack), 32'd1);
        #1;
        rst_n = 1'b0;
        h_req = 1'b0;
        #1;
        check("t6_ack_drops", 32'(h_ack), 32'd0);
        check("t6_valid_drops", 32'(f_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_held_ack", 32'(h_ack), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_release_no_valid", 32'(f_valid), 32'd0);
        check("t6_release_no_ack", 32'(h_ack), 32'd0);
        @(negedge clk);
        check("t6_valid_after_grant", 32'(f_valid), 32'd1);

        repeat (5) @(negedge clk);
        check("hq_drained", 32'(hq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
